mod_exp_engine: RTL
===================

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 g  input  32  base, unsigned.
REQ-005 e  input  32  exponent, unsigned.
REQ-006 p  input  32  modulus, unsigned.
REQ-007 result  output  32  g^e mod p; held until the next accepted start.
REQ-008 busy  output  1  high from start acceptance until done.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 err  output  1  set with done when p==0; cleared on the next accepted start.

Function
REQ-011 The block SHALL capture g, e and p on the edge that accepts start; later input changes have no effect on the operation in flight.
REQ-012 FSM states SHALL be IDLE, INIT_RED, MUL_A, RED_A, MUL_B, RED_B, FINISH.
REQ-013 IDLE with start=1 SHALL go to INIT_RED, set busy=1, acc=1, bit index=0; if p==0, it SHALL go to FINISH instead, with result=0 and err=1.
REQ-014 INIT_RED SHALL reduce g mod p into base using the sequential reducer (64 cycles), then go to MUL_A.
REQ-015 MUL_A SHALL form the 64-bit product acc*base in one cycle; RED_A SHALL reduce it mod p (64 cycles) and store it into acc only if e[index]==1.
REQ-016 MUL_B SHALL form the 64-bit product base*base in one cycle; RED_B SHALL reduce it mod p and store it into base, then increment index.
REQ-017 After RED_B with index==31, the FSM SHALL go to FINISH; otherwise it SHALL return to MUL_A.
REQ-018 All 32 exponent bits SHALL be processed regardless of e, giving constant time: done SHALL pulse exactly 4226 cycles after the accepting edge (1+64+32*130+1).
REQ-019 FINISH SHALL load result with acc (mod p), pulse done, clear busy, and return to IDLE; a start in that same cycle SHALL be ignored.
REQ-020 Reducer: rem (33-bit) SHALL be cleared, then for i=63 down to 0: rem={rem[31:0],x[i]}, and if rem>=p then rem=rem-p; one bit per cycle, and the final rem SHALL be less than p.
REQ-021 With p==1, result SHALL be 0.
REQ-022 With e==0 and p>1, result SHALL be 1.
REQ-023 With g>=p, g SHALL be reduced first; results SHALL equal those for g mod p.
REQ-024 start while busy SHALL be ignored, with no effect on state.

Reset
REQ-025 rst low SHALL force IDLE immediately, at any state including mid-operation.
REQ-026 Reset values SHALL be: result=1, busy=0, done=0, err=0, acc=1, base=0, index=0, reducer state=0.
REQ-027 After rst is released, the block SHALL accept a new start on the first edge without residue from the aborted operation.

Structure
REQ-028 A shared package SHALL hold the state enumeration, WIDTH=32, PROD_WIDTH=64 and the latency constant 4226.
REQ-029 The shift-subtract reducer SHALL be a sub-module, mod_reduce_seq, with start/busy/done handshake, 64-bit operand, 32-bit modulus and 32-bit remainder; one instance SHALL be shared by INIT_RED, RED_A and RED_B.

Verification
REQ-030 g=5, e=6, p=23, start -> done after 4226 cycles, result=8, err=0.
REQ-031 g=2, e=0xFFFFFFFF, p=0xFFFFFFFB -> result matches the golden model; latency is 4226 cycles, the same as for e=1.
REQ-032 p=0 -> done on the 2nd cycle after start, result=0, err=1; p=1 -> result=0; e=0, p=23 -> result=1.
REQ-033 g=100, p=23 -> result equals that for g=8 with the same e; start reasserted at cycle 100 of a run -> ignored, result unchanged.
REQ-034 rst asserted at cycle 2000 -> busy=0, result=1 at once; a new start for g=3, e=4, p=7 -> result=4.

Source files
------------

// File: rtl/mod_exp_engine_pkg.sv
// Shared types and constants for the constant-time modular exponentiation
// engine and its sequential reducer.
package mod_exp_engine_pkg;

   localparam int WIDTH      = 32;
   localparam int PROD_WIDTH = 64;
   localparam int IDX_W      = 5;
   localparam int LATENCY    = 4226;

   typedef enum logic [2:0] {
      IDLE,
      INIT_RED,
      MUL_A,
      RED_A,
      MUL_B,
      RED_B,
      FINISH
   } state_t;

endpackage

// File: rtl/mod_reduce_seq.sv
// Shift-subtract reducer: x mod m, one operand bit per cycle, MSB first.
// done is asserted in the last busy cycle, alongside the final remainder.
module mod_reduce_seq
   import mod_exp_engine_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [PROD_WIDTH-1:0] x,
   input  logic [WIDTH-1:0]      m,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      rem
);

   logic [PROD_WIDTH-1:0] sh;
   logic [WIDTH-1:0]      r;
   logic [WIDTH-1:0]      m_q;
   logic [5:0]            cnt;
   logic                  busy_q;

   logic [WIDTH:0]        t;
   logic [WIDTH:0]        t_sub;
   logic [WIDTH-1:0]      r_nx;

   always_comb begin
      t     = {r, sh[PROD_WIDTH-1]};
      t_sub = t - {1'b0, m_q};
      r_nx  = t[WIDTH-1:0];
      // r < m always holds, so the subtracted value fits in WIDTH bits
      if (t >= {1'b0, m_q}) begin
         r_nx = t_sub[WIDTH-1:0];
      end
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt == 6'd63);
   assign rem  = r_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh     <= '0;
         r      <= '0;
         m_q    <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
      end else if (start && !busy_q) begin
         sh     <= x;
         r      <= '0;
         m_q    <= m;
         cnt    <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         sh  <= {sh[PROD_WIDTH-2:0], 1'b0};
         r   <= r_nx;
         cnt <= cnt + 6'd1;
         if (cnt == 6'd63) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mod_exp_engine.sv
// Constant-time right-to-left square-and-multiply: g^e mod p.
// All 32 exponent bits are always walked; one shared reducer does every mod.
module mod_exp_engine
   import mod_exp_engine_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t state, state_nx;

   logic [WIDTH-1:0]      g_q, e_q, p_q;
   logic [WIDTH-1:0]      acc, base;
   logic [IDX_W-1:0]      idx;

   logic                  red_start;
   logic [PROD_WIDTH-1:0] red_x;
   logic                  red_busy;
   logic                  red_done;
   logic [WIDTH-1:0]      red_rem;

   mod_reduce_seq u_red (
      .clk   (clk),
      .rst   (rst),
      .start (red_start),
      .x     (red_x),
      .m     (p_q),
      .busy  (red_busy),
      .done  (red_done),
      .rem   (red_rem)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      red_start = 1'b0;
      red_x     = '0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = (p == '0) ? FINISH : INIT_RED;
            end
         end
         INIT_RED: begin
            red_start = !red_busy;
            red_x     = {{(PROD_WIDTH-WIDTH){1'b0}}, g_q};
            if (red_done) begin
               state_nx = MUL_A;
            end
         end
         MUL_A: begin
            red_start = 1'b1;
            red_x     = PROD_WIDTH'(acc) * PROD_WIDTH'(base);
            state_nx  = RED_A;
         end
         RED_A: begin
            if (red_done) begin
               state_nx = MUL_B;
            end
         end
         MUL_B: begin
            red_start = 1'b1;
            red_x     = PROD_WIDTH'(base) * PROD_WIDTH'(base);
            state_nx  = RED_B;
         end
         RED_B: begin
            if (red_done) begin
               state_nx = (idx == 5'd31) ? FINISH : MUL_A;
            end
         end
         FINISH: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g_q    <= '0;
         e_q    <= '0;
         p_q    <= '0;
         acc    <= WIDTH'(1);
         base   <= '0;
         idx    <= '0;
         result <= WIDTH'(1);
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  g_q <= g;
                  e_q <= e;
                  p_q <= p;
                  acc <= WIDTH'(1);
                  idx <= '0;
                  err <= 1'b0;
               end
            end
            INIT_RED: begin
               if (red_done) begin
                  base <= red_rem;
               end
            end
            RED_A: begin
               if (red_done && e_q[idx]) begin
                  acc <= red_rem;
               end
            end
            RED_B: begin
               if (red_done) begin
                  base <= red_rem;
                  idx  <= idx + 5'd1;
               end
            end
            FINISH: begin
               done <= 1'b1;
               err  <= (p_q == '0);
               // acc is already reduced except for the initial 1 when p==1
               if (p_q == '0) begin
                  result <= '0;
               end else if (acc >= p_q) begin
                  result <= acc - p_q;
               end else begin
                  result <= acc;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
